// File: rtl/move_buffer.sv
// move_buffer: FIFO of coordinated-move records between the SPI decoder and the stepper timing routine
// Ports: CLK, reset (sync, active-high), flush; wr_valid/wr_dir/wr_duration/wr_increment/wr_incrincr push with wr_ready;
// rd_valid/rd_dir/rd_duration/rd_increment/rd_incrincr first-word-fall-through head, popped by rd_done;
// count, sticky overflow/underrun cleared by clear_flags; moves_completed/drops active only with MOVE_BUFFER_STATS_EN.
module move_buffer #(
  parameter int MOVE_BUFFER_BITS = 2,
  parameter int DATA_W = 64
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wr_valid,
  input  logic                      wr_dir,
  input  logic [DATA_W-1:0]         wr_duration,
  input  logic [DATA_W-1:0]         wr_increment,
  input  logic [DATA_W-1:0]         wr_incrincr,
  output logic                      wr_ready,
  output logic                      rd_valid,
  output logic                      rd_dir,
  output logic [DATA_W-1:0]         rd_duration,
  output logic [DATA_W-1:0]         rd_increment,
  output logic [DATA_W-1:0]         rd_incrincr,
  input  logic                      rd_done,
  output logic [MOVE_BUFFER_BITS:0] count,
  output logic                      overflow,
  output logic                      underrun,
  input  logic                      clear_flags,
  output logic [31:0]               moves_completed,
  output logic [7:0]                drops
);
  localparam int DEPTH = 1 << MOVE_BUFFER_BITS;
  localparam int EW = 3 * DATA_W + 1;
  localparam logic [MOVE_BUFFER_BITS-1:0] PONE = MOVE_BUFFER_BITS'(1);
  localparam logic [MOVE_BUFFER_BITS:0] CONE = (MOVE_BUFFER_BITS + 1)'(1);
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [MOVE_BUFFER_BITS-1:0] wr_ptr, rd_ptr;
  logic full, empty, push_ok, pop_ok, ovf_ev, und_ev;
  assign full = count[MOVE_BUFFER_BITS];
  assign empty = count == '0;
  assign push_ok = wr_valid && !flush && (!full || rd_done);
  assign pop_ok = rd_done && !flush && !empty;
  assign ovf_ev = wr_valid && !flush && full && !rd_done;
  assign und_ev = rd_done && !flush && empty;
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign head = rd_valid ? mem[rd_ptr] : '0;
  assign {rd_dir, rd_duration, rd_increment, rd_incrincr} = head;
  always_ff @(posedge CLK)
    if (push_ok) mem[wr_ptr] <= {wr_dir, wr_duration, wr_increment, wr_incrincr};
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PONE;
        if (pop_ok) rd_ptr <= rd_ptr + PONE;
        if (push_ok != pop_ok) count <= push_ok ? count + CONE : count - CONE;
      end
      overflow <= ovf_ev || (overflow && !clear_flags);
      underrun <= und_ev || (underrun && !clear_flags);
    end
  end
`ifdef MOVE_BUFFER_STATS_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      moves_completed <= '0;
      drops <= '0;
    end else begin
      if (pop_ok) moves_completed <= moves_completed + 32'd1;
      if (ovf_ev && drops != 8'hff) drops <= drops + 8'd1;
    end
  end
`else
  assign moves_completed = '0;
  assign drops = '0;
`endif
endmodule
